score_display_ctrl: RTL and testbench
=====================================

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 Port CLOCK_50, input, 1, sole clock; all state updates on its rising edge.
REQ-002 Port reset, input, 1, synchronous active-high reset, sampled on CLOCK_50 rising edge.
REQ-003 Port mode, input, 2, game select: 0 = idle, 1 = react, 2 = chimp, 3 = treated as idle.
REQ-004 Port screen, input, 2, react screen index; 3 = result screen.
REQ-005 Port react_current, input, 12, react current score, unsigned binary.
REQ-006 Port react_high, input, 12, react high score, unsigned binary.
REQ-007 Port chimp_level, input, 5, chimp level, unsigned binary.
REQ-008 Ports digit0..digit3, output, 4 each, registered BCD digits; digit0 = ones.
REQ-009 Port blank, output, 4, registered per-digit blank flags, bit i blanks digit i.
REQ-010 Port busy, output, 1, high while a conversion is in flight.
REQ-011 Port update, output, 1, one-cycle pulse when the digit and blank outputs change.

Function
REQ-012 Source select: mode 1 with screen 3 selects react_current.
REQ-013 Source select: mode 1 with any other screen selects react_high.
REQ-014 Source select: mode 2 selects chimp_level zero-extended to 12 bits.
REQ-015 Source select: mode 0 or 3 selects constant 0.
REQ-016 The FSM has three states, IDLE, CONVERT and COMMIT; reset state is IDLE.
REQ-017 In IDLE, when the selected value or the chimp/non-chimp selection differs from the last committed snapshot, the block captures a snapshot on that edge and enters CONVERT; otherwise it stays in IDLE.
REQ-018 CONVERT performs exactly 12 double-dabble iterations, one per cycle: add 3 to each BCD nibble that is >= 5, then shift left by 1; an iteration counter runs 0..11.
REQ-019 After iteration 11 the FSM enters COMMIT; COMMIT registers the digits and blank flags, pulses update, and returns to IDLE.
REQ-020 Latency: with the capture on edge k, outputs change and update is high after edge k+13; busy is high from edge k through edge k+12.
REQ-021 Input changes during CONVERT or COMMIT do not affect the conversion in flight; the compare in REQ-017 then triggers a new capture on the edge after COMMIT.
REQ-022 Blanking: leading-zero digits are blanked, and digit0 is never blanked.
REQ-023 Blanking: in chimp selection, digits 2 and 3 are always blanked.
REQ-024 Arithmetic: 12-bit input maximum is 4095, so there is no saturation; the BCD shift register is 16 BCD bits plus 12 binary bits.
REQ-025 update is never asserted for two consecutive cycles.
REQ-026 update is never asserted outside COMMIT.

Reset
REQ-027 On reset: state goes to IDLE and the iteration counter to 0.
REQ-028 On reset: digit0..digit3 go to 0, blank to 4'b1110, busy to 0 and update to 0.
REQ-029 On reset: the committed snapshot goes to value 0, non-chimp.
REQ-030 Reset asserted mid-CONVERT or in COMMIT aborts the conversion with no update pulse.
REQ-031 After reset deasserts, a nonzero selected value triggers a capture on the first IDLE edge.

Structure
REQ-032 A shared package holds:
- the state enum (IDLE, CONVERT, COMMIT);
- the mode codes MODE_IDLE=0, MODE_REACT=1, MODE_CHIMP=2;
- SCREEN_RESULT=3;
- SCORE_W=12, LEVEL_W=5, NUM_DIGITS=4.
REQ-033 One combinational sub-module, bcd_dabble_step, performs a single add-3-then-shift iteration; it is instantiated once.

Verification
REQ-034 Reset held for 3 cycles -> digits 0,0,0,0; blank=1110; busy=0; update=0.
REQ-035 mode=1, screen=3, react_current=1234 -> 13 edges after capture: digit3..0=1,2,3,4, blank=0000, update high for exactly 1 cycle.
REQ-036 mode=1, screen=0, react_high=4095 -> digit3..0=4,0,9,5, blank=0000.
REQ-037 mode=2, chimp_level=7 -> digit0=7, blank=1110; then chimp_level=31 -> digit1..0=3,1, blank=1100.
REQ-038 react_current changes 1234->56 at the 5th CONVERT cycle -> first commit shows 1234; a second commit 14 cycles later shows 5,6 with blank=1100; two update pulses in total.
REQ-039 reset asserted during the 6th CONVERT cycle -> next edge: IDLE, digits 0, blank=1110, no update pulse; after release the selected value is reconverted.

Source files
------------

// File: rtl/score_display_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// score_display_ctrl_pkg
// Shared types and constants for the score display controller:
//   - controller state enum (IDLE, CONVERT, COMMIT)
//   - game mode codes and the react "result" screen index
//   - data widths (binary score, chimp level, BCD digit count, shift register)
//   - select_source(): picks the binary value to be shown for a mode/screen
// -----------------------------------------------------------------------------
package score_display_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_IDLE     = 2'd0;
    localparam logic [1:0] MODE_REACT    = 2'd1;
    localparam logic [1:0] MODE_CHIMP    = 2'd2;
    localparam logic [1:0] SCREEN_RESULT = 2'd3;

    localparam int SCORE_W    = 12;
    localparam int LEVEL_W    = 5;
    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4 * NUM_DIGITS;     // 16 BCD bits
    localparam int SR_W       = BCD_W + SCORE_W;    // BCD part + binary part
    localparam int ITER_W     = 4;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(SCORE_W - 1);

    // Value to display for the current game selection. Mode 3 behaves as idle.
    function automatic logic [SCORE_W-1:0] select_source(
        input logic [1:0]         mode,
        input logic [1:0]         screen,
        input logic [SCORE_W-1:0] react_current,
        input logic [SCORE_W-1:0] react_high,
        input logic [LEVEL_W-1:0] chimp_level
    );
        logic [SCORE_W-1:0] val;
        val = '0;
        if (mode == MODE_REACT) begin
            val = (screen == SCREEN_RESULT) ? react_current : react_high;
        end else if (mode == MODE_CHIMP) begin
            val = {{(SCORE_W-LEVEL_W){1'b0}}, chimp_level};
        end
        return val;
    endfunction

endpackage

// File: rtl/score_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// score_display_ctrl_if
// Bundle between the game logic and the score display controller.
//   master : game side, drives mode/screen/scores/level, reads display outputs
//   slave  : controller side, reads the game state, drives digits/blank/busy/update
// Signals:
//   mode[1:0], screen[1:0], react_current[11:0], react_high[11:0],
//   chimp_level[4:0]                      game -> controller
//   digit0..digit3[3:0] (digit0 = ones), blank[3:0], busy, update
//                                         controller -> game/display
// -----------------------------------------------------------------------------
interface score_display_ctrl_if;
    import score_display_ctrl_pkg::*;

    logic [1:0]         mode;
    logic [1:0]         screen;
    logic [SCORE_W-1:0] react_current;
    logic [SCORE_W-1:0] react_high;
    logic [LEVEL_W-1:0] chimp_level;
    logic [3:0]         digit0;
    logic [3:0]         digit1;
    logic [3:0]         digit2;
    logic [3:0]         digit3;
    logic [3:0]         blank;
    logic               busy;
    logic               update;

    modport master (
        output mode, screen, react_current, react_high, chimp_level,
        input  digit0, digit1, digit2, digit3, blank, busy, update
    );

    modport slave (
        input  mode, screen, react_current, react_high, chimp_level,
        output digit0, digit1, digit2, digit3, blank, busy, update
    );

endinterface

// File: rtl/score_display_ctrl_bcd_dabble_step.sv
// -----------------------------------------------------------------------------
// bcd_dabble_step
// One combinational double-dabble iteration over the {BCD, binary} shift
// register: every BCD nibble >= 5 gets +3, then the whole register shifts
// left by one bit.
// Ports:
//   sr_i [SR_W-1:0]  register before the iteration
//   sr_o [SR_W-1:0]  register after adjust + shift
// -----------------------------------------------------------------------------
module bcd_dabble_step
    import score_display_ctrl_pkg::*;
(
    input  logic [SR_W-1:0] sr_i,
    output logic [SR_W-1:0] sr_o
);

    logic [SR_W-1:0] adjusted;

    assign adjusted[SCORE_W-1:0] = sr_i[SCORE_W-1:0];

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
            logic [3:0] nib;
            assign nib = sr_i[SCORE_W + 4*gi +: 4];
            assign adjusted[SCORE_W + 4*gi +: 4] = (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
        end
    endgenerate

    assign sr_o = {adjusted[SR_W-2:0], 1'b0};

endmodule

// File: rtl/score_display_ctrl.sv
// -----------------------------------------------------------------------------
// score_display_ctrl
// Watches the selected game value and, whenever it (or the chimp/non-chimp
// selection) differs from the last captured snapshot, converts it to four BCD
// digits with a 12-cycle double-dabble and commits digits plus leading-zero
// blank flags in one go, pulsing update for a single cycle.
// Ports:
//   CLOCK_50  sole clock, rising edge
//   reset     synchronous active-high reset
//   bus       score_display_ctrl_if.slave (inputs from game, display outputs)
// Timing: capture on edge k, busy high after edges k..k+12, outputs and
// update change after edge k+13.
// -----------------------------------------------------------------------------
module score_display_ctrl
    import score_display_ctrl_pkg::*;
(
    input  logic                 CLOCK_50,
    input  logic                 reset,
    score_display_ctrl_if.slave  bus
);

    state_t              state_q;
    logic [ITER_W-1:0]   iter_q;
    logic [SR_W-1:0]     sr_q;
    logic [SCORE_W-1:0]  snap_val_q;
    logic                snap_chimp_q;
    logic [BCD_W-1:0]    digits_q;
    logic [3:0]          blank_q;
    logic                busy_q;
    logic                update_q;

    logic [SCORE_W-1:0]  sel_val;
    logic                sel_chimp;
    logic [SR_W-1:0]     sr_d;
    logic [BCD_W-1:0]    bcd_res;
    logic [NUM_DIGITS-1:0] dig_zero;
    logic [NUM_DIGITS-1:0] blank_d;

    assign sel_val   = select_source(bus.mode, bus.screen, bus.react_current,
                                     bus.react_high, bus.chimp_level);
    assign sel_chimp = (bus.mode == MODE_CHIMP);

    bcd_dabble_step u_step (
        .sr_i (sr_q),
        .sr_o (sr_d)
    );

    // Blank flags are derived from the finished conversion in sr_q while in
    // COMMIT, so they land in the same cycle as the digits.
    assign bcd_res = sr_q[SR_W-1:SCORE_W];

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
            assign dig_zero[gi] = (bcd_res[4*gi +: 4] == 4'd0);
            if (gi == 0) begin : g_ones
                assign blank_d[gi] = 1'b0;
            end else if (gi >= 2) begin : g_upper
                // Chimp levels never exceed two digits, so the upper pair stays dark.
                assign blank_d[gi] = (&dig_zero[NUM_DIGITS-1:gi]) | snap_chimp_q;
            end else begin : g_mid
                assign blank_d[gi] = &dig_zero[NUM_DIGITS-1:gi];
            end
        end
    endgenerate

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= IDLE;
            iter_q       <= '0;
            sr_q         <= '0;
            snap_val_q   <= '0;
            snap_chimp_q <= 1'b0;
            digits_q     <= '0;
            blank_q      <= 4'b1110;
            busy_q       <= 1'b0;
            update_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    update_q <= 1'b0;
                    if ((sel_val != snap_val_q) || (sel_chimp != snap_chimp_q)) begin
                        snap_val_q   <= sel_val;
                        snap_chimp_q <= sel_chimp;
                        sr_q         <= {{BCD_W{1'b0}}, sel_val};
                        iter_q       <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= CONVERT;
                    end
                end
                CONVERT: begin
                    sr_q   <= sr_d;
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == ITER_LAST) begin
                        iter_q  <= '0;
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    digits_q <= bcd_res;
                    blank_q  <= blank_d;
                    update_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    update_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.digit0 = digits_q[3:0];
    assign bus.digit1 = digits_q[7:4];
    assign bus.digit2 = digits_q[11:8];
    assign bus.digit3 = digits_q[15:12];
    assign bus.blank  = blank_q;
    assign bus.busy   = busy_q;
    assign bus.update = update_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_display_ctrl
// Directed stimulus pushes the expected commit (cycle, digits, blank) into a
// queue; a monitor pops and compares on every update pulse.
// -----------------------------------------------------------------------------
module tb_score_display_ctrl;

    typedef struct {
        int          cyc;
        logic [15:0] dig;
        logic [3:0]  blk;
        string       name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_assert;
    int   n_fail;
    bit   prev_upd;
    exp_t exp_q[$];

    score_display_ctrl_if bus_if ();

    score_display_ctrl dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: one line per update pulse.
    always @(negedge clk) begin
        if (bus_if.update) begin
            exp_t e;
            n_assert++;
            if (prev_upd) begin
                n_fail++;
                $display("FAIL update_width: update high at cycle %0d and previous cycle, required single-cycle pulse", cyc);
            end
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_update: pulse at cycle %0d digits=%h blank=%b, required no pulse",
                         cyc, {bus_if.digit3, bus_if.digit2, bus_if.digit1, bus_if.digit0}, bus_if.blank);
            end else begin
                e = exp_q.pop_front();
                n_assert++;
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL %s_latency: pulse at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
                end
                if ({bus_if.digit3, bus_if.digit2, bus_if.digit1, bus_if.digit0} != e.dig ||
                    bus_if.blank != e.blk) begin
                    n_fail++;
                    $display("FAIL %s_data: digits=%h blank=%b, required digits=%h blank=%b", e.name,
                             {bus_if.digit3, bus_if.digit2, bus_if.digit1, bus_if.digit0}, bus_if.blank,
                             e.dig, e.blk);
                end else begin
                    $display("commit %s at cycle %0d: digits=%h blank=%b", e.name, cyc, e.dig, e.blk);
                end
            end
        end
        prev_upd = bus_if.update;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end else begin
            $display("check %s: %0h", name, act);
        end
    endtask

    // Return at the falling edge once the cycle counter reaches t.
    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [15:0] d, input logic [3:0] b, input string nm);
        exp_t e;
        e.cyc = c; e.dig = d; e.blk = b; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] d, input logic [3:0] b,
                                 input logic bsy, input logic upd);
        check({tag, "_digits"}, 32'({bus_if.digit3, bus_if.digit2, bus_if.digit1, bus_if.digit0}), 32'(d));
        check({tag, "_blank"},  32'(bus_if.blank), 32'(b));
        check({tag, "_busy"},   32'(bus_if.busy),  32'(bsy));
        check({tag, "_update"}, 32'(bus_if.update), 32'(upd));
    endtask

    int n;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        prev_upd = 1'b0;
        rst      = 1'b1;
        bus_if.mode          = 2'd0;
        bus_if.screen        = 2'd0;
        bus_if.react_current = 12'd0;
        bus_if.react_high    = 12'd0;
        bus_if.chimp_level   = 5'd0;

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", 16'h0000, 4'b1110, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cyc(cyc + 3);

        // React result screen, current score 1234, with busy window checks.
        @(posedge clk); #1;
        n = cyc;
        bus_if.mode = 2'd1; bus_if.screen = 2'd3; bus_if.react_current = 12'd1234;
        push(n + 14, 16'h1234, 4'b0000, "react_cur_1234");
        wait_cyc(n + 1);  check("busy_after_capture", 32'(bus_if.busy), 32'd1);
        wait_cyc(n + 13); check("busy_last_convert",  32'(bus_if.busy), 32'd1);
        wait_cyc(n + 14); check("busy_after_commit",  32'(bus_if.busy), 32'd0);
        wait_cyc(n + 20);

        // React high score at the 12-bit maximum.
        @(posedge clk); #1;
        n = cyc;
        bus_if.screen = 2'd0; bus_if.react_high = 12'd4095;
        push(n + 14, 16'h4095, 4'b0000, "react_high_4095");
        wait_cyc(n + 20);

        // Chimp level 7, then 31.
        @(posedge clk); #1;
        n = cyc;
        bus_if.mode = 2'd2; bus_if.chimp_level = 5'd7;
        push(n + 14, 16'h0007, 4'b1110, "chimp_7");
        wait_cyc(n + 20);
        @(posedge clk); #1;
        n = cyc;
        bus_if.chimp_level = 5'd31;
        push(n + 14, 16'h0031, 4'b1100, "chimp_31");
        wait_cyc(n + 20);

        // Input change 1234 -> 56 during the 5th CONVERT cycle.
        @(posedge clk); #1;
        n = cyc;
        bus_if.mode = 2'd1; bus_if.screen = 2'd3; bus_if.react_current = 12'd1234;
        push(n + 14, 16'h1234, 4'b0000, "midchange_first");
        push(n + 28, 16'h0056, 4'b1100, "midchange_second");
        @(posedge clk); #1;
        wait_cyc(n + 5);
        bus_if.react_current = 12'd56;
        wait_cyc(n + 35);

        // Reset during the 6th CONVERT cycle aborts, then value is reconverted.
        @(posedge clk); #1;
        n = cyc;
        bus_if.react_current = 12'd789;
        wait_cyc(n + 6);
        rst = 1'b1;
        wait_cyc(n + 7);
        check_outputs("abort", 16'h0000, 4'b1110, 1'b0, 1'b0);
        rst = 1'b0;
        push(n + 21, 16'h0789, 4'b1000, "reconvert_789");
        wait_cyc(n + 30);

        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_update: %0d expected commits never seen, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
